uart_seq_driver: RTL and testbench
==================================

# uart_seq_driver

Synthesisable frame sequencer that sits between control logic and the UART transmitter/receiver pair. It streams a programmable frame of up to DEPTH bytes into the UART transmitter, one byte per transmission, with a configurable idle gap between bytes. Optionally it waits for a single response byte, with a timeout, and it can repeat the frame continuously. It replaces hand-written byte-by-byte stimulus with a reusable block usable both on silicon and in benches.

## Interface
Parameters:
- NB_DATA, 8, byte width; must match the UART.
- DEPTH, 8, frame table entries (≥2).
- NB_GAP, 8, width of the inter-byte gap counter.
- NB_TIMEOUT, 12, width of the response timeout counter.
- NB_COUNT, 16, width of the frame counter.

Ports:
- i_Clock, in, 1, single clock; all logic on its rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_wr_en, in, 1, table write strobe; honoured only in IDLE.
- i_wr_addr, in, clog2(DEPTH), table write address.
- i_wr_data, in, NB_DATA, table write data.
- i_len, in, clog2(DEPTH+1), bytes per frame; latched at start; values above DEPTH are clamped to DEPTH.
- i_gap, in, NB_GAP, idle cycles between end of one byte and start of the next; latched at start.
- i_wait_rx, in, 1, expect one response byte after the last byte; latched at start.
- i_repeat, in, 1, restart the frame after completion; sampled live at each frame end.
- i_start, in, 1, one-cycle start pulse.
- i_abort, in, 1, abandon the current frame.
- o_tx_start, out, 1, one-cycle start pulse to the UART transmitter.
- o_tx_byte, out, NB_DATA, byte presented with o_tx_start; held until the next load.
- i_tx_active, in, 1, UART transmitter busy.
- i_rx_done, in, 1, one-cycle pulse from the UART receiver.
- i_rx_data, in, NB_DATA, received byte, valid with i_rx_done.
- o_busy, out, 1, high in every state except IDLE.
- o_frame_done, out, 1, one-cycle pulse at the end of each frame.
- o_timeout, out, 1, one-cycle pulse, coincident with o_frame_done, when no response arrived.
- o_rx_valid, out, 1, one-cycle pulse when the response is captured.
- o_rx_data, out, NB_DATA, last captured response byte.
- o_frame_count, out, NB_COUNT, number of completed frames; wraps.

## Operation
- States: IDLE, LOAD, SEND, GAP, WAIT_RX, DONE.
- **IDLE:** table writes are accepted here. i_start with latched len>0 moves to LOAD and clears idx. i_start with i_len=0 is ignored.
- **LOAD:** if i_tx_active=0, assert o_tx_start for one cycle with o_tx_byte=table[idx] and go to SEND. Otherwise stay in LOAD.
- **SEND:** byte completion is the falling edge of i_tx_active, detected from a registered copy whose reset value is 1.
  - On completion, if idx=len-1: go to WAIT_RX when wait_rx=1, else DONE.
  - On completion, if idx<len-1: increment idx, then go to GAP when gap>0, else LOAD.
- **GAP:** count gap cycles, then go to LOAD.
- **WAIT_RX:** the timeout counter runs from 0.
  - i_rx_done captures i_rx_data into o_rx_data, pulses o_rx_valid, and goes to DONE.
  - If the counter reaches 2^NB_TIMEOUT-1 with no i_rx_done, pulse o_timeout and go to DONE.
  - If i_rx_done and expiry occur in the same cycle, the response wins and there is no timeout.
- **DONE:** pulse o_frame_done and increment o_frame_count. If i_repeat=1, clear idx and go to GAP (gap>0) or LOAD. Otherwise go to IDLE.
- **Abort:** i_abort in any non-IDLE state goes to IDLE on the next cycle.
  - No o_frame_done, count unchanged, no o_tx_start.
  - A byte already handed to the UART is not recalled.
  - Abort has priority over every other transition.
- i_start while busy is ignored. i_wr_en while busy is ignored and the table is unchanged.

## Timing
- Reset values:
  - state IDLE, idx 0, table all 0.
  - o_tx_start 0, o_tx_byte 0, o_busy 0, o_frame_done 0, o_timeout 0, o_rx_valid 0, o_rx_data 0, o_frame_count 0.
- i_start at cycle n with the transmitter idle gives o_tx_start at n+1 (LOAD entered at n+1, output registered in the same state).
- i_tx_active sampled low at cycle k after being high at k-1 (completion) gives the next o_tx_start at k+1+gap.
- Completion of the last byte, with wait_rx=0, gives o_frame_done one cycle after DONE is entered.
- o_busy falls in the cycle IDLE is re-entered.
- Reset asserted mid-frame takes effect on the next edge regardless of UART state.

## Structure
- Package uart_seq_pkg holds the state encoding localparams and a clog2 function.
- The FSM, gap counter and timeout counter stay in uart_seq_driver.
- One sub-module, uart_seq_table: a DEPTH×NB_DATA register file with a synchronous write port, an asynchronous read port and synchronous reset.

## Test plan
- Load 0x16, 0x12, 0x20; len=3, gap=0, wait_rx=0; start → three o_tx_start pulses carrying 0x16, 0x12, 0x20, each issued the cycle after the previous completion. Then one o_frame_done, o_frame_count=1.
- Same frame with gap=5 → every second and third o_tx_start lands exactly 6 cycles after the preceding completion edge.
- wait_rx=1, UART looped back to return 0x34 → o_rx_valid with o_rx_data=0x34. Then o_frame_done with o_timeout=0.
- wait_rx=1, NB_TIMEOUT=4, no response → o_timeout and o_frame_done together, 15 cycles after WAIT_RX is entered. Separately, i_rx_done on the expiry cycle → o_timeout=0.
- i_abort during the second byte's SEND → IDLE the next cycle, no further o_tx_start, count unchanged. i_wr_en during SEND leaves the table intact. i_start with len=0 → o_busy stays 0.
- i_repeat=1, len=2 for three frames → six tx bytes and o_frame_count=3. Drop i_repeat → IDLE after the current frame. Reset mid-frame → all outputs at their reset values next cycle.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: state encoding and width helper shared by the UART frame sequencer
package uart_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND    = 3'd2,
    S_GAP     = 3'd3,
    S_WAIT_RX = 3'd4,
    S_DONE    = 3'd5
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_seq_table.sv
// uart_seq_table: frame byte register file, sync write, async read, sync clear
module uart_seq_table #(
  parameter int NB_DATA = 8,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input  logic               i_Clock,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);
  logic [NB_DATA-1:0] mem [DEPTH];
  always_ff @(posedge i_Clock) begin
    if (i_reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end
  assign o_rd_data = mem[i_rd_addr];
endmodule

// File: rtl/uart_seq_driver.sv
// uart_seq_driver: streams a programmable byte frame into a UART with gaps, optional response wait and repeat
module uart_seq_driver
  import uart_seq_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int DEPTH      = 8,
  parameter int NB_GAP     = 8,
  parameter int NB_TIMEOUT = 12,
  parameter int NB_COUNT   = 16
) (
  input  logic                       i_Clock,
  input  logic                       i_reset,
  input  logic                       i_wr_en,
  input  logic [clog2(DEPTH)-1:0]    i_wr_addr,
  input  logic [NB_DATA-1:0]         i_wr_data,
  input  logic [clog2(DEPTH+1)-1:0]  i_len,
  input  logic [NB_GAP-1:0]          i_gap,
  input  logic                       i_wait_rx,
  input  logic                       i_repeat,
  input  logic                       i_start,
  input  logic                       i_abort,
  output logic                       o_tx_start,
  output logic [NB_DATA-1:0]         o_tx_byte,
  input  logic                       i_tx_active,
  input  logic                       i_rx_done,
  input  logic [NB_DATA-1:0]         i_rx_data,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_timeout,
  output logic                       o_rx_valid,
  output logic [NB_DATA-1:0]         o_rx_data,
  output logic [NB_COUNT-1:0]        o_frame_count
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH+1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  // leaving on this value means the counter reaches its all-ones terminal count
  localparam logic [NB_TIMEOUT-1:0] TO_LAST = ~NB_TIMEOUT'(1);
  state_t state;
  logic [AW-1:0] idx;
  logic [LW-1:0] len, len_in;
  logic [NB_GAP-1:0] gap, gcnt;
  logic [NB_TIMEOUT-1:0] tcnt;
  logic [NB_DATA-1:0] rd_data;
  logic wait_rx, tx_q, timed_out, last, fall;
  uart_seq_table #(.NB_DATA(NB_DATA), .DEPTH(DEPTH), .AW(AW)) u_table (
    .i_Clock   (i_Clock),
    .i_reset   (i_reset),
    .i_wr_en   (i_wr_en && state == S_IDLE),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (idx),
    .o_rd_data (rd_data)
  );
  assign len_in = (i_len > DEPTH_L) ? DEPTH_L : i_len;
  assign last   = LW'(idx) == len - 1'b1;
  assign fall   = tx_q && !i_tx_active;
  assign o_busy = state != S_IDLE;
  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      len           <= '0;
      gap           <= '0;
      gcnt          <= '0;
      tcnt          <= '0;
      wait_rx       <= 1'b0;
      timed_out     <= 1'b0;
      tx_q          <= 1'b1;
      o_tx_start    <= 1'b0;
      o_tx_byte     <= '0;
      o_frame_done  <= 1'b0;
      o_timeout     <= 1'b0;
      o_rx_valid    <= 1'b0;
      o_rx_data     <= '0;
      o_frame_count <= '0;
    end else begin
      tx_q         <= i_tx_active;
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      o_timeout    <= 1'b0;
      o_rx_valid   <= 1'b0;
      if (i_abort && state != S_IDLE) state <= S_IDLE;
      else case (state)
        S_IDLE: if (i_start && len_in != '0) begin
          len     <= len_in;
          gap     <= i_gap;
          wait_rx <= i_wait_rx;
          idx     <= '0;
          state   <= S_LOAD;
        end
        S_LOAD: if (!i_tx_active) begin
          o_tx_start <= 1'b1;
          o_tx_byte  <= rd_data;
          state      <= S_SEND;
        end
        S_SEND: if (fall) begin
          gcnt      <= '0;
          tcnt      <= '0;
          timed_out <= 1'b0;
          if (last) state <= wait_rx ? S_WAIT_RX : S_DONE;
          else begin
            idx   <= idx + 1'b1;
            state <= (gap != '0) ? S_GAP : S_LOAD;
          end
        end
        S_GAP: begin
          gcnt <= gcnt + 1'b1;
          if (gcnt == gap - 1'b1) state <= S_LOAD;
        end
        S_WAIT_RX: begin
          tcnt <= tcnt + 1'b1;
          if (i_rx_done) begin
            o_rx_data  <= i_rx_data;
            o_rx_valid <= 1'b1;
            state      <= S_DONE;
          end else if (tcnt == TO_LAST) begin
            timed_out <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          o_frame_done  <= 1'b1;
          o_timeout     <= timed_out;
          o_frame_count <= o_frame_count + 1'b1;
          timed_out     <= 1'b0;
          gcnt          <= '0;
          idx           <= '0;
          state         <= !i_repeat ? S_IDLE : (gap != '0) ? S_GAP : S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_seq_driver.sv
// tb_uart_seq_driver: randomized directed bench with a UART model and an arithmetic timing model
module tb_uart_seq_driver;
  localparam int NB_DATA = 8, DEPTH = 8, NB_GAP = 8, NB_TIMEOUT = 4, NB_COUNT = 16;
  localparam int TO_CYC = 1 << NB_TIMEOUT;
  logic i_Clock = 0, i_reset = 1, i_wr_en = 0, i_wait_rx = 0, i_repeat = 0, i_start = 0, i_abort = 0;
  logic i_tx_active = 0, i_rx_done = 0;
  logic [2:0] i_wr_addr = '0;
  logic [3:0] i_len = '0;
  logic [7:0] i_wr_data = '0, i_gap = '0, i_rx_data = '0;
  logic o_tx_start, o_busy, o_frame_done, o_timeout, o_rx_valid;
  logic [7:0] o_tx_byte, o_rx_data;
  logic [15:0] o_frame_count;
  uart_seq_driver #(.NB_DATA(NB_DATA), .DEPTH(DEPTH), .NB_GAP(NB_GAP), .NB_TIMEOUT(NB_TIMEOUT), .NB_COUNT(NB_COUNT)) dut (
    .i_Clock(i_Clock), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_len(i_len), .i_gap(i_gap), .i_wait_rx(i_wait_rx), .i_repeat(i_repeat), .i_start(i_start), .i_abort(i_abort),
    .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte), .i_tx_active(i_tx_active), .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_timeout(o_timeout),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .o_frame_count(o_frame_count)
  );
  always #5 i_Clock = ~i_Clock;
  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;
  int checks = 0, failures = 0, start_s = 0, exp_cnt = 0;
  int tx_dur = 2, busy_left = 0, rx_cnt = 0, loop_n = 0, rx_dly = 1;
  bit loop_en = 0;
  int tx_c[$], fall_c[$], fd_c[$], rv_c[$], exp_c[$], exp_i[$], exp_fd[$];
  logic [7:0] tx_b[$], rv_d[$];
  bit fd_to[$];
  logic [7:0] tbl [DEPTH];
  // UART transmitter/receiver model plus event log, edge numbers taken from cyc
  always @(negedge i_Clock) begin
    i_rx_done = 0;
    if (rx_cnt > 0) begin
      rx_cnt--;
      if (rx_cnt == 0) begin i_rx_done = 1; i_rx_data = 8'h34; end
    end
    if (o_tx_start) begin
      tx_c.push_back(cyc); tx_b.push_back(o_tx_byte);
      i_tx_active = 1; busy_left = tx_dur;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        i_tx_active = 0;
        fall_c.push_back(cyc + 1);
        if (loop_en && tx_b.size() == loop_n) rx_cnt = rx_dly;
      end
    end
    if (o_frame_done) begin fd_c.push_back(cyc); fd_to.push_back(o_timeout); end
    if (o_rx_valid) begin rv_c.push_back(cyc); rv_d.push_back(o_rx_data); end
  end
  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge i_Clock); #1;
  endtask
  task automatic wr(input int a, input logic [7:0] d);
    i_wr_en = 1; i_wr_addr = 3'(a); i_wr_data = d;
    step();
    i_wr_en = 0;
  endtask
  task automatic go(input int len, input int gap, input bit wrx);
    i_len = 4'(len); i_gap = 8'(gap); i_wait_rx = wrx; i_start = 1; start_s = cyc + 1;
    step();
    i_start = 0;
  endtask
  task automatic clr();
    tx_c.delete(); tx_b.delete(); fall_c.delete(); fd_c.delete(); fd_to.delete(); rv_c.delete(); rv_d.delete();
  endtask
  task automatic wait_fd(input int n, input int budget);
    for (int i = 0; i < budget && fd_c.size() < n; i++) step();
    chk("frame_done_wait", 32'(fd_c.size() >= n), 1);
  endtask
  task automatic wait_tx(input int n);
    for (int i = 0; i < 100 && tx_c.size() < n; i++) step();
    chk("tx_start_wait", 32'(tx_c.size() >= n), 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && (o_busy || i_tx_active); i++) step();
    chk("idle_wait", {o_busy, i_tx_active}, 0);
  endtask
  task automatic chk_reset(input string pfx);
    chk({pfx, "_tx_start"}, o_tx_start, 0);
    chk({pfx, "_tx_byte"}, o_tx_byte, 0);
    chk({pfx, "_busy"}, o_busy, 0);
    chk({pfx, "_frame_done"}, o_frame_done, 0);
    chk({pfx, "_timeout"}, o_timeout, 0);
    chk({pfx, "_rx_valid"}, o_rx_valid, 0);
    chk({pfx, "_rx_data"}, o_rx_data, 0);
    chk({pfx, "_frame_count"}, o_frame_count, 0);
  endtask
  // Expected tx edges: first byte one edge after start; each completion lands d+1 edges after its
  // start pulse; next byte 1+gap after completion; frame_done one edge after DONE; repeat restarts 1+gap later.
  function automatic void model(input int s, input int len, input int d, input int gap, input int nfr);
    int t;
    t = s + 1;
    exp_c.delete(); exp_i.delete(); exp_fd.delete();
    for (int fr = 0; fr < nfr; fr++) begin
      for (int i = 0; i < len; i++) begin
        exp_c.push_back(t); exp_i.push_back(i);
        t += d + 1;
        if (i < len - 1) t += 1 + gap;
      end
      exp_fd.push_back(t + 1);
      t += 2 + gap;
    end
  endfunction
  task automatic check_frames(input bit to);
    chk("tx_count", tx_c.size(), exp_c.size());
    for (int i = 0; i < tx_c.size() && i < exp_c.size(); i++) begin
      chk("tx_cycle", tx_c[i], exp_c[i]);
      chk("tx_byte", tx_b[i], tbl[exp_i[i]]);
    end
    chk("fd_count", fd_c.size(), exp_fd.size());
    for (int i = 0; i < fd_c.size() && i < exp_fd.size(); i++) begin
      chk("fd_cycle", fd_c[i], exp_fd[i]);
      chk("fd_timeout", fd_to[i], to);
    end
  endtask
  initial begin
    int g, f, len;
    repeat (3) step();
    i_reset = 0;
    step();
    chk_reset("reset");
    tbl[0] = 8'h16; tbl[1] = 8'h12; tbl[2] = 8'h20;
    for (int i = 3; i < DEPTH; i++) tbl[i] = 8'($urandom);
    for (int i = 0; i < DEPTH; i++) wr(i, tbl[i]);
    // basic frame, no gap
    clr(); tx_dur = $urandom_range(1, 4);
    go(3, 0, 0); wait_fd(1, 200);
    model(start_s, 3, tx_dur, 0, 1); check_frames(0);
    exp_cnt++;
    chk("count_basic", o_frame_count, exp_cnt);
    chk("busy_after_frame", o_busy, 0);
    // gap of 5 cycles
    clr(); tx_dur = $urandom_range(1, 4);
    go(3, 5, 0); wait_fd(1, 200);
    model(start_s, 3, tx_dur, 5, 1); check_frames(0);
    for (int i = 0; i < 2 && fall_c.size() >= 3 && tx_c.size() >= 3; i++)
      chk("gap_after_completion", tx_c[i+1] - fall_c[i], 6);
    exp_cnt++;
    chk("count_gap", o_frame_count, exp_cnt);
    // looped-back response
    clr(); tx_dur = $urandom_range(1, 4); g = $urandom_range(0, 2);
    loop_en = 1; loop_n = 3; rx_dly = $urandom_range(1, 14);
    go(3, g, 1); wait_fd(1, 300);
    model(start_s, 3, tx_dur, g, 1);
    f = exp_c[2] + tx_dur + 1;
    exp_fd[0] = f + rx_dly + 1;
    check_frames(0);
    chk("rx_valid_count", rv_c.size(), 1);
    if (rv_c.size() > 0) begin
      chk("rx_valid_cycle", rv_c[0], f + rx_dly);
      chk("rx_valid_data", rv_d[0], 8'h34);
    end
    chk("rx_data_hold", o_rx_data, 8'h34);
    exp_cnt++;
    // no response: timeout
    clr(); loop_en = 0; tx_dur = $urandom_range(1, 4); len = $urandom_range(1, 3);
    go(len, 0, 1); wait_fd(1, 300);
    model(start_s, len, tx_dur, 0, 1);
    f = exp_c[len-1] + tx_dur + 1;
    exp_fd[0] = f + TO_CYC;
    check_frames(1);
    chk("timeout_no_rx_valid", rv_c.size(), 0);
    chk("timeout_rx_data_kept", o_rx_data, 8'h34);
    exp_cnt++;
    // response on the expiry cycle wins
    clr(); loop_en = 1; loop_n = 2; rx_dly = TO_CYC - 1; tx_dur = $urandom_range(1, 4);
    go(2, 0, 1); wait_fd(1, 300);
    model(start_s, 2, tx_dur, 0, 1);
    f = exp_c[1] + tx_dur + 1;
    exp_fd[0] = f + TO_CYC;
    check_frames(0);
    chk("expiry_rx_valid_count", rv_c.size(), 1);
    if (rv_c.size() > 0) chk("expiry_rx_valid_cycle", rv_c[0], f + TO_CYC - 1);
    loop_en = 0; exp_cnt++;
    chk("count_after_rx", o_frame_count, exp_cnt);
    // write while busy is ignored, abort during second byte
    wait_idle(); clr(); tx_dur = $urandom_range(1, 4);
    go(3, 0, 0);
    wait_tx(1);
    i_wr_en = 1; i_wr_addr = 3'd1; i_wr_data = ~tbl[1];
    step();
    i_wr_en = 0;
    wait_tx(2);
    i_abort = 1;
    step();
    i_abort = 0;
    chk("abort_busy", o_busy, 0);
    repeat (20) step();
    chk("abort_tx_count", tx_c.size(), 2);
    if (tx_b.size() > 1) chk("busy_write_ignored", tx_b[1], tbl[1]);
    chk("abort_no_done", fd_c.size(), 0);
    chk("abort_count", o_frame_count, exp_cnt);
    // zero length start is ignored
    go(0, 0, 0);
    chk("len0_busy", o_busy, 0);
    repeat (5) step();
    chk("len0_no_tx", tx_c.size(), 2);
    // repeat for three frames
    wait_idle(); clr(); tx_dur = $urandom_range(1, 4); g = $urandom_range(0, 3);
    i_repeat = 1;
    go(2, g, 0); wait_fd(2, 400);
    i_repeat = 0;
    wait_fd(3, 400);
    repeat (30) step();
    model(start_s, 2, tx_dur, g, 3); check_frames(0);
    exp_cnt += 3;
    chk("repeat_count", o_frame_count, exp_cnt);
    chk("repeat_idle", o_busy, 0);
    // reset mid-frame, then table must read back as zero
    wait_idle(); clr(); tx_dur = 4;
    go(3, 0, 0);
    wait_tx(1);
    i_reset = 1;
    step();
    chk_reset("midreset");
    i_reset = 0;
    wait_idle(); clr();
    go(1, 0, 0); wait_fd(1, 200);
    chk("cleared_table_byte", tx_b.size() > 0 ? tx_b[0] : 8'hxx, 8'h00);
    chk("count_after_reset", o_frame_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
